// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - instruction fetch with icache/memory fallback, branch pre-decode and 8-deep fetch queue; optional FETCH_PERF_CNT_EN counters
module fetch_queue_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int QUEUE_LOG  = 3,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clr_in,
    input  logic [ADDR_WIDTH-1:0] rob_to_if_alter_pc,
    output logic [ADDR_WIDTH-1:0] if_to_ic_addr,
    input  logic                  ic_to_if_hit,
    input  logic [INST_WIDTH-1:0] ic_to_if_hit_inst,
    output logic                  if_to_ic_wr_valid,
    output logic [ADDR_WIDTH-1:0] if_to_ic_wr_addr,
    output logic [INST_WIDTH-1:0] if_to_ic_wr_inst,
    output logic                  if_to_mc_valid,
    output logic [ADDR_WIDTH-1:0] if_to_mc_addr,
    input  logic                  mc_to_if_ready,
    input  logic [INST_WIDTH-1:0] mc_to_if_inst,
    output logic [ADDR_WIDTH-1:0] if_to_pr_pc,
    input  logic                  pr_to_if_taken,
    input  logic                  dc_stall,
    output logic                  if_to_dc_valid,
    output logic [INST_WIDTH-1:0] if_to_dc_inst,
    output logic [ADDR_WIDTH-1:0] if_to_dc_pc,
    output logic                  if_to_dc_pred_br
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_hit_cnt,
    output logic [31:0]           perf_miss_cnt,
    output logic [31:0]           perf_full_stall_cnt
`endif
);
    localparam int DEPTH = 1 << QUEUE_LOG;
    localparam int CW    = QUEUE_LOG + 1;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [QUEUE_LOG-1:0]  head, tail;
    logic [CW-1:0]         count;
    logic [INST_WIDTH-1:0] q_inst [DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc   [DEPTH];
    logic                  q_pred [DEPTH];

    logic                  full, push, pop, fill, issue;
    logic [INST_WIDTH-1:0] fetch_inst;
    logic [ADDR_WIDTH-1:0] j_imm, b_imm, next_pc;
    logic                  pred;

    assign full             = count[QUEUE_LOG];
    assign if_to_ic_addr    = pc;
    assign if_to_pr_pc      = pc;
    assign if_to_dc_valid   = (count != '0);
    assign if_to_dc_inst    = q_inst[head];
    assign if_to_dc_pc      = q_pc[head];
    assign if_to_dc_pred_br = q_pred[head];
    assign pop              = if_to_dc_valid && !dc_stall && !clr_in;

    // Pre-decode the instruction being pushed: cache data in IDLE, memory data otherwise
    always_comb begin
        fetch_inst = (state == S_IDLE) ? ic_to_if_hit_inst : mc_to_if_inst;
        j_imm = {{(ADDR_WIDTH-20){fetch_inst[31]}}, fetch_inst[19:12], fetch_inst[20],
                 fetch_inst[30:21], 1'b0};
        b_imm = {{(ADDR_WIDTH-12){fetch_inst[31]}}, fetch_inst[7], fetch_inst[30:25],
                 fetch_inst[11:8], 1'b0};
        pred    = 1'b0;
        next_pc = pc + ADDR_WIDTH'(4);
        if (fetch_inst[6:0] == OP_JAL) begin
            pred    = 1'b1;
            next_pc = pc + j_imm;
        end else if (fetch_inst[6:0] == OP_BRANCH) begin
            pred = pr_to_if_taken;
            if (pr_to_if_taken) next_pc = pc + b_imm;
        end
    end

    // FSM state register
    always_ff @(posedge clk_in) begin
        if (rst_in)      state <= S_IDLE;
        else if (rdy_in) state <= state_next;
    end

    // FSM next state; a returning read always ends WAIT/DISCARD, even under flush
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (issue) state_next = S_WAIT;
            S_WAIT:    if (mc_to_if_ready) state_next = S_IDLE;
                       else if (clr_in)    state_next = S_DISCARD;
            S_DISCARD: if (mc_to_if_ready) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // FSM actions: push into queue, cache fill, new memory request
    always_comb begin
        push  = 1'b0;
        fill  = 1'b0;
        issue = 1'b0;
        case (state)
            S_IDLE: if (!clr_in && !full) begin
                if (ic_to_if_hit) push  = 1'b1;
                else              issue = 1'b1;
            end
            S_WAIT: if (mc_to_if_ready) begin
                fill = 1'b1;
                push = !clr_in;
            end
            S_DISCARD: fill = mc_to_if_ready;
            default: ;
        endcase
    end

    // PC, queue storage/pointers and registered memory/cache interface
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc                <= RESET_PC;
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            if_to_mc_valid    <= 1'b0;
            if_to_mc_addr     <= '0;
            if_to_ic_wr_valid <= 1'b0;
            if_to_ic_wr_addr  <= '0;
            if_to_ic_wr_inst  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_inst[i] <= '0;
                q_pc[i]   <= '0;
                q_pred[i] <= 1'b0;
            end
        end else if (rdy_in) begin
            if (clr_in)    pc <= rob_to_if_alter_pc;
            else if (push) pc <= next_pc;

            if (clr_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    q_inst[tail] <= fetch_inst;
                    q_pc[tail]   <= pc;
                    q_pred[tail] <= pred;
                    tail         <= tail + 1'b1;
                end
                if (pop) head <= head + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end

            if (issue) begin
                if_to_mc_valid <= 1'b1;
                if_to_mc_addr  <= pc;
            end else if (fill) begin
                if_to_mc_valid <= 1'b0;
            end

            if_to_ic_wr_valid <= fill;
            if (fill) begin
                if_to_ic_wr_addr <= if_to_mc_addr;
                if_to_ic_wr_inst <= mc_to_if_inst;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating event counters: hit pushes, miss requests, full-queue IDLE cycles
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            perf_hit_cnt        <= '0;
            perf_miss_cnt       <= '0;
            perf_full_stall_cnt <= '0;
        end else if (rdy_in) begin
            if (state == S_IDLE && push && perf_hit_cnt != '1)
                perf_hit_cnt <= perf_hit_cnt + 32'd1;
            if (issue && perf_miss_cnt != '1)
                perf_miss_cnt <= perf_miss_cnt + 32'd1;
            if (state == S_IDLE && !clr_in && full && perf_full_stall_cnt != '1)
                perf_full_stall_cnt <= perf_full_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - directed self-checking bench for fetch_queue_unit
module tb_fetch_queue_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] JAL = 32'h0100_006F;
    localparam logic [31:0] BEQ = 32'h0000_0463;

    logic        clk = 1'b0;
    logic        rst, rdy, clr;
    logic [31:0] alter_pc;
    logic [31:0] ic_addr;
    logic        hit;
    logic [31:0] hit_inst;
    logic        wr_valid;
    logic [31:0] wr_addr, wr_inst;
    logic        mc_valid;
    logic [31:0] mc_addr;
    logic        mc_ready;
    logic [31:0] mc_inst;
    logic [31:0] pr_pc;
    logic        taken;
    logic        stall;
    logic        dc_valid;
    logic [31:0] dc_inst, dc_pc;
    logic        dc_pred;

    int n_asrt = 0;
    int n_fail = 0;

    fetch_queue_unit dut (
        .clk_in             (clk),
        .rst_in             (rst),
        .rdy_in             (rdy),
        .clr_in             (clr),
        .rob_to_if_alter_pc (alter_pc),
        .if_to_ic_addr      (ic_addr),
        .ic_to_if_hit       (hit),
        .ic_to_if_hit_inst  (hit_inst),
        .if_to_ic_wr_valid  (wr_valid),
        .if_to_ic_wr_addr   (wr_addr),
        .if_to_ic_wr_inst   (wr_inst),
        .if_to_mc_valid     (mc_valid),
        .if_to_mc_addr      (mc_addr),
        .mc_to_if_ready     (mc_ready),
        .mc_to_if_inst      (mc_inst),
        .if_to_pr_pc        (pr_pc),
        .pr_to_if_taken     (taken),
        .dc_stall           (stall),
        .if_to_dc_valid     (dc_valid),
        .if_to_dc_inst      (dc_inst),
        .if_to_dc_pc        (dc_pc),
        .if_to_dc_pred_br   (dc_pred)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; clr = 1'b0; alter_pc = '0;
        hit = 1'b0; hit_inst = '0; mc_ready = 1'b0; mc_inst = '0;
        taken = 1'b0; stall = 1'b0;
        step(); step();

        chk("rst_ic_addr",  64'(ic_addr),  64'h0);
        chk("rst_pr_pc",    64'(pr_pc),    64'h0);
        chk("rst_dc_valid", 64'(dc_valid), 64'h0);
        chk("rst_mc_valid", 64'(mc_valid), 64'h0);
        chk("rst_wr_valid", 64'(wr_valid), 64'h0);
        chk("rst_dc_inst",  64'(dc_inst),  64'h0);

        // back-to-back hits
        rst = 1'b0; hit = 1'b1; hit_inst = NOP;
        step();
        chk("hit0_valid", 64'(dc_valid), 64'h1);
        chk("hit0_pc",    64'(dc_pc),    64'h0);
        chk("hit0_inst",  64'(dc_inst),  64'(NOP));
        chk("hit0_pred",  64'(dc_pred),  64'h0);
        step();
        chk("hit1_pc",    64'(dc_pc),    64'h4);
        step();
        chk("hit2_pc",    64'(dc_pc),    64'h8);
        chk("hit2_pred",  64'(dc_pred),  64'h0);

        // miss at 0x0 serviced by memory
        rst = 1'b1; step();
        rst = 1'b0; hit = 1'b0;
        step();
        chk("miss_req_valid", 64'(mc_valid), 64'h1);
        chk("miss_req_addr",  64'(mc_addr),  64'h0);
        chk("miss_no_push",   64'(dc_valid), 64'h0);
        step(); step();
        chk("miss_hold_valid", 64'(mc_valid), 64'h1);
        chk("miss_hold_addr",  64'(mc_addr),  64'h0);
        mc_ready = 1'b1; mc_inst = NOP; stall = 1'b1;
        step();
        mc_ready = 1'b0;
        chk("miss_done_valid", 64'(mc_valid), 64'h0);
        chk("fill_valid",      64'(wr_valid), 64'h1);
        chk("fill_addr",       64'(wr_addr),  64'h0);
        chk("fill_inst",       64'(wr_inst),  64'(NOP));
        chk("miss_head_pc",    64'(dc_pc),    64'h0);
        chk("miss_head_inst",  64'(dc_inst),  64'(NOP));
        chk("miss_next_pc",    64'(ic_addr),  64'h4);
        step();
        chk("fill_one_cycle",  64'(wr_valid), 64'h0);

        // JAL then BEQ pre-decode
        rst = 1'b1; step();
        rst = 1'b0; stall = 1'b0; clr = 1'b1; alter_pc = 32'h10;
        step();
        chk("flush_idle_pc", 64'(ic_addr), 64'h10);
        chk("flush_idle_no_req", 64'(mc_valid), 64'h0);
        clr = 1'b0; hit = 1'b1; hit_inst = JAL;
        step();
        chk("jal_next_pc", 64'(ic_addr), 64'h20);
        chk("jal_head_pc", 64'(dc_pc),   64'h10);
        chk("jal_pred",    64'(dc_pred), 64'h1);
        hit_inst = BEQ; taken = 1'b1;
        step();
        chk("beq_taken_next", 64'(ic_addr), 64'h28);
        chk("beq_taken_head", 64'(dc_pc),   64'h20);
        chk("beq_taken_pred", 64'(dc_pred), 64'h1);

        // flush together with push and pop in IDLE
        clr = 1'b1; alter_pc = 32'h20;
        step();
        chk("flush_pp_empty", 64'(dc_valid), 64'h0);
        chk("flush_pp_pc",    64'(ic_addr),  64'h20);
        clr = 1'b0; taken = 1'b0;
        step();
        chk("beq_nt_next", 64'(ic_addr), 64'h24);
        chk("beq_nt_head", 64'(dc_pc),   64'h20);
        chk("beq_nt_pred", 64'(dc_pred), 64'h0);

        // fill to full under decoder stall, then drain and wrap
        rst = 1'b1; step();
        rst = 1'b0; stall = 1'b1; hit_inst = NOP;
        for (int i = 0; i < 8; i++) step();
        chk("full_pc", 64'(ic_addr), 64'h20);
        step(); step();
        chk("full_no_push_pc", 64'(ic_addr), 64'h20);
        chk("full_no_req",     64'(mc_valid), 64'h0);
        chk("full_head_pc",    64'(dc_pc),    64'h0);
        stall = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("drain_head_%0d", k), 64'(dc_pc), 64'(4 * k));
        end
        chk("drain_refill_pc", 64'(ic_addr), 64'h3C);

        // flush during WAIT -> DISCARD
        rst = 1'b1; step();
        rst = 1'b0; hit = 1'b0;
        step();
        chk("disc_req", 64'(mc_valid), 64'h1);
        clr = 1'b1; alter_pc = 32'h80;
        step();
        clr = 1'b0;
        chk("disc_empty",  64'(dc_valid), 64'h0);
        chk("disc_pc",     64'(ic_addr),  64'h80);
        chk("disc_valid",  64'(mc_valid), 64'h1);
        step();
        chk("disc_hold",   64'(mc_valid), 64'h1);
        mc_ready = 1'b1; mc_inst = JAL;
        step();
        mc_ready = 1'b0;
        chk("disc_fill",      64'(wr_valid), 64'h1);
        chk("disc_fill_addr", 64'(wr_addr),  64'h0);
        chk("disc_fill_inst", 64'(wr_inst),  64'(JAL));
        chk("disc_no_push",   64'(dc_valid), 64'h0);
        chk("disc_pc_kept",   64'(ic_addr),  64'h80);
        chk("disc_drop",      64'(mc_valid), 64'h0);
        hit = 1'b1; hit_inst = NOP;
        step();
        chk("disc_then_hit_head", 64'(dc_pc),   64'h80);
        chk("disc_then_hit_next", 64'(ic_addr), 64'h84);

        // global enable low holds everything
        rdy = 1'b0;
        step(); step();
        chk("rdy_hold_pc",   64'(ic_addr), 64'h84);
        chk("rdy_hold_head", 64'(dc_pc),   64'h80);
        rdy = 1'b1;

        // reset mid-WAIT, later ready ignored
        hit = 1'b0; stall = 1'b1;
        step();
        chk("wait2_req", 64'(mc_valid), 64'h1);
        rst = 1'b1;
        step();
        chk("rst_wait_valid", 64'(mc_valid), 64'h0);
        chk("rst_wait_pc",    64'(ic_addr),  64'h0);
        rst = 1'b0; hit = 1'b1; hit_inst = NOP; mc_ready = 1'b1; mc_inst = JAL;
        step();
        mc_ready = 1'b0;
        chk("late_ready_no_fill", 64'(wr_valid), 64'h0);
        chk("late_ready_pc",      64'(ic_addr),  64'h4);
        chk("late_ready_inst",    64'(dc_inst),  64'(NOP));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
